mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: XLEN, default 64, datapath width in bits.
REQ-002 clock  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1_data  input  XLEN  operand A, fed from register-file readdata1.
REQ-007 rs2_data  input  XLEN  operand B, fed from register-file readdata2.
REQ-008 rd_in  input  5  destination register tag.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result and rd_out are valid.
REQ-011 result  output  XLEN  operation result; drives register-file writedata.
REQ-012 rd_out  output  5  latched rd_in; drives register-file rd.
REQ-013 writereg  output  1  equals done; drives register-file writereg.

Function
REQ-014 States: IDLE, BUSY, DONE; IDLE->BUSY on start, BUSY->DONE after XLEN iterations, DONE->IDLE unconditionally.
REQ-015 On accept at edge T: latch op, operands, rd_in; clear iteration counter; busy high from T.
REQ-016 Fixed latency: done high exactly in the cycle after edge T+XLEN+1, for one cycle; next accept possible the following cycle.
REQ-017 start while busy is ignored; no queuing.
REQ-018 Multiply: radix-2 shift-add over absolute values, 2*XLEN-bit product, sign applied at end.
REQ-019 MUL returns product[XLEN-1:0]; MULH, MULHSU, MULHU return product[2*XLEN-1:XLEN] with signed*signed, signed*unsigned, and unsigned*unsigned operands respectively.
REQ-020 Divide: restoring, one quotient bit per iteration over absolute values; quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-021 Divide by zero: DIV/DIVU quotient all ones; REM/REMU return A; latency unchanged.
REQ-022 Signed overflow (A = most negative, B = -1): DIV returns A; REM returns 0; latency unchanged.
REQ-023 result and rd_out hold their last values outside done; they are not cleared after DONE.

Reset
REQ-024 reset low forces IDLE immediately, regardless of clock, and aborts any operation in flight without a done pulse.
REQ-025 Reset values: busy 0, done 0, writereg 0, result 0, rd_out 0, counter 0.
REQ-026 start is ignored while reset is low; the first accept is possible on the first edge after reset deasserts.

Configuration
REQ-027 Macro MUL_DIV_UNIT_DIV_EN: when defined, divide ops 4-7 behave per REQ-020..022.
REQ-028 When MUL_DIV_UNIT_DIV_EN is undefined: no divider logic; ops 4-7 go IDLE->DONE (done one cycle after accept), result 0, writereg 1.

Structure
REQ-029 Package mul_div_pkg holds XLEN default, the op encodings, and the state encoding.
REQ-030 One sub-module, mul_div_abs: combinational conditional two's-complement negate, instantiated for operand abs and result sign fix.

Verification
REQ-031 MUL: A=7, B=-3 -> done at start+XLEN+1, result=-21, writereg=1, rd_out=rd_in.
REQ-032 MULHU: A=B=2^64-1 -> result=2^64-2; MULH: A=-1, B=-1 -> result=0.
REQ-033 DIV: A=-20, B=6 -> quotient -3; REM -> -2; DIVU: A=20, B=0 -> all ones; REMU -> 20.
REQ-034 DIV: A=0x8000_0000_0000_0000, B=-1 -> result=A; REM -> 0.
REQ-035 start pulsed during BUSY -> ignored, exactly one done; reset low mid-BUSY -> busy=0 immediately, no done, next op correct.
REQ-036 Without MUL_DIV_UNIT_DIV_EN: DIV A=9, B=3 -> done one cycle after accept, result=0.

Source files
------------

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the default datapath width, the op encodings, the FSM state
// encoding and small op-decode helpers.
package mul_div_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operand A is interpreted as signed for these ops.
    function automatic logic op_signed_a(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    // Operand B is interpreted as signed for these ops.
    function automatic logic op_signed_b(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mul_div_abs.sv
// mul_div_abs: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to re-apply the result sign.
module mul_div_abs #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    // Negate when requested, otherwise pass the value through unchanged.
    always_comb begin
        if (neg) begin
            y = ~a + {{(W-1){1'b0}}, 1'b1};
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with fixed latency.
// Multiply is radix-2 shift-add over magnitudes, divide is restoring;
// both take XLEN iterations and share the hi/lo working registers.
// Divide support is compiled in only when MUL_DIV_UNIT_DIV_EN is defined;
// otherwise ops 4-7 complete one cycle after accept with result 0.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            writereg
);

    localparam int            CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
`ifdef MUL_DIV_UNIT_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    state_e            state_r;
    state_e            state_nx_s;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [XLEN-1:0]   b_r;
    logic [CW-1:0]     cnt_r;
    logic              neg_q_r;
    logic [4:0]        rd_lat_r;
    logic [4:0]        rd_out_r;
    logic [XLEN-1:0]   result_r;
    logic              done_r;

    logic              sa_s;
    logic              sb_s;
    logic [XLEN-1:0]   a_abs_s;
    logic [XLEN-1:0]   b_abs_s;
    logic              accept_s;
    logic              bypass_s;
    logic              cnt_done_s;
    logic [XLEN:0]     add_s;
    logic [XLEN-1:0]   mul_hi_s;
    logic [XLEN-1:0]   mul_lo_s;
    logic [XLEN-1:0]   step_hi_s;
    logic [XLEN-1:0]   step_lo_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   final_s;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [XLEN-1:0]   a_r;
    logic              neg_r_r;
    logic              div0_r;
    logic [XLEN:0]     sh_s;
    logic [XLEN-1:0]   sub_s;
    logic              ge_s;
    logic [XLEN-1:0]   div_hi_s;
    logic [XLEN-1:0]   div_lo_s;
    logic [XLEN-1:0]   q_fix_s;
    logic [XLEN-1:0]   r_fix_s;
`endif

    assign sa_s       = op_signed_a(op) & rs1_data[XLEN-1];
    assign sb_s       = op_signed_b(op) & rs2_data[XLEN-1];
    assign accept_s   = (state_r == ST_IDLE) & start;
    // Divide ops skip the iteration entirely when no divider is built.
    assign bypass_s   = ~DIV_EN & op[2];
    assign cnt_done_s = (cnt_r == CNT_LAST);

    mul_div_abs #(.W(XLEN)) u_abs_a (.a(rs1_data), .neg(sa_s), .y(a_abs_s));
    mul_div_abs #(.W(XLEN)) u_abs_b (.a(rs2_data), .neg(sb_s), .y(b_abs_s));
    mul_div_abs #(.W(2*XLEN)) u_fix_prod (.a({hi_r, lo_r}), .neg(neg_q_r), .y(prod_fix_s));
`ifdef MUL_DIV_UNIT_DIV_EN
    mul_div_abs #(.W(XLEN)) u_fix_quot (.a(lo_r), .neg(neg_q_r), .y(q_fix_s));
    mul_div_abs #(.W(XLEN)) u_fix_rem  (.a(hi_r), .neg(neg_r_r), .y(r_fix_s));
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: BUSY holds for XLEN iterations plus one finalise edge.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (bypass_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_done_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // One shift-add multiply step: conditionally add multiplicand, shift {hi,lo} right.
    always_comb begin
        if (lo_r[0]) begin
            add_s = {1'b0, hi_r} + {1'b0, b_r};
        end else begin
            add_s = {1'b0, hi_r};
        end
        mul_hi_s = add_s[XLEN:1];
        mul_lo_s = {add_s[0], lo_r[XLEN-1:1]};
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // One restoring divide step: shift dividend bit into remainder, subtract if it fits.
    always_comb begin
        sh_s  = {hi_r, lo_r[XLEN-1]};
        ge_s  = (sh_s >= {1'b0, b_r});
        // The difference always fits in XLEN bits when it is kept.
        sub_s = sh_s[XLEN-1:0] - b_r;
        if (ge_s) begin
            div_hi_s = sub_s;
        end else begin
            div_hi_s = sh_s[XLEN-1:0];
        end
        div_lo_s = {lo_r[XLEN-2:0], ge_s};
    end
`endif

    // Select the iteration step for the latched op.
    always_comb begin
`ifdef MUL_DIV_UNIT_DIV_EN
        if (op_r[2]) begin
            step_hi_s = div_hi_s;
            step_lo_s = div_lo_s;
        end else begin
            step_hi_s = mul_hi_s;
            step_lo_s = mul_lo_s;
        end
`else
        step_hi_s = mul_hi_s;
        step_lo_s = mul_lo_s;
`endif
    end

    // Final result selection with sign fix and divide corner cases.
    always_comb begin
        final_s = '0;
        case (op_r)
            OP_MUL:                       final_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_fix_s[2*XLEN-1:XLEN];
`ifdef MUL_DIV_UNIT_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (div0_r) begin
                    final_s = '1;
                end else begin
                    final_s = q_fix_s;
                end
            end
            OP_REM, OP_REMU: begin
                if (div0_r) begin
                    final_s = a_r;
                end else begin
                    final_s = r_fix_s;
                end
            end
`endif
            default: final_s = '0;
        endcase
    end

    // Working registers: load magnitudes on accept, iterate while BUSY.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_r     <= 3'd0;
            hi_r     <= '0;
            lo_r     <= '0;
            b_r      <= '0;
            cnt_r    <= '0;
            neg_q_r  <= 1'b0;
            rd_lat_r <= 5'd0;
`ifdef MUL_DIV_UNIT_DIV_EN
            a_r      <= '0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
`endif
        end else begin
            if (accept_s) begin
                op_r     <= op;
                hi_r     <= '0;
                lo_r     <= a_abs_s;
                b_r      <= b_abs_s;
                cnt_r    <= '0;
                neg_q_r  <= sa_s ^ sb_s;
                rd_lat_r <= rd_in;
`ifdef MUL_DIV_UNIT_DIV_EN
                a_r      <= rs1_data;
                neg_r_r  <= sa_s;
                div0_r   <= (rs2_data == '0);
`endif
            end else if ((state_r == ST_BUSY) && !cnt_done_s) begin
                hi_r  <= step_hi_s;
                lo_r  <= step_lo_s;
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Output registers: result/rd_out update only on the edge entering DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_r <= '0;
            rd_out_r <= 5'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_nx_s == ST_DONE);
            if (accept_s && bypass_s) begin
                result_r <= '0;
                rd_out_r <= rd_in;
            end else if ((state_r == ST_BUSY) && cnt_done_s) begin
                result_r <= final_s;
                rd_out_r <= rd_lat_r;
            end else begin
                result_r <= result_r;
                rd_out_r <= rd_out_r;
            end
        end
    end

    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;
    assign writereg = done_r;
    assign result   = result_r;
    assign rd_out   = rd_out_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (XLEN=64).
// Divide vectors are exercised when MUL_DIV_UNIT_DIV_EN is defined; the
// bypass behaviour of ops 4-7 is exercised otherwise.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int XLEN = 64;

    logic            clock;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            writereg;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .writereg(writereg)
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one op and wait (bounded) for done; lat counts edges after accept, -1 on timeout.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, output logic [63:0] res, output logic [4:0] rdo,
                          output logic wr, output int lat, output logic busy0);
        @(negedge clock);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        busy0 = busy;
        lat = -1; res = '0; rdo = 5'd0; wr = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k; res = result; rdo = rd_out; wr = writereg;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = OP_MUL; rs1_data = 64'd3; rs2_data = 64'd4; rd_in = 5'd7;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (writereg !== 1'b0) begin errors++; $display("FAIL reset_writereg got %b exp 0", writereg); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out got %h exp 0", rd_out); end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
    endtask

    task automatic test_mul();
        logic [63:0] res; logic [4:0] rdo; logic wr; int lat; logic b0;
        run_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, res, rdo, wr, lat, b0);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mul_busy got %b exp 1", b0); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL mul_latency got %0d exp 65", lat); end
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_result got %h exp ffffffffffffffeb", res); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL mul_writereg got %b exp 1", wr); end
        checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd_out got %0d exp 5", rdo); end
    endtask

    task automatic test_mulh();
        logic [63:0] res; logic [4:0] rdo; logic wr; int lat; logic b0;
        run_op(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_result got %h exp fffffffffffffffe", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL mulhu_latency got %0d exp 65", lat); end
        run_op(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL mulh_result got %h exp 0", res); end
        run_op(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_result got %h exp ffffffffffffffff", res); end
        checks++; if (rdo !== 5'd3) begin errors++; $display("FAIL mulhsu_rd_out got %0d exp 3", rdo); end
    endtask

`ifdef MUL_DIV_UNIT_DIV_EN
    task automatic test_div();
        logic [63:0] res; logic [4:0] rdo; logic wr; int lat; logic b0;
        run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd10, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_result got %h exp fffffffffffffffd", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL div_latency got %0d exp 65", lat); end
        run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd11, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_result got %h exp fffffffffffffffe", res); end
        run_op(OP_DIVU, 64'd20, 64'd0, 5'd12, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_zero_result got %h exp ffffffffffffffff", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL divu_zero_latency got %0d exp 65", lat); end
        run_op(OP_REMU, 64'd20, 64'd0, 5'd13, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'd20) begin errors++; $display("FAIL remu_zero_result got %h exp 14", res); end
        run_op(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL div_ovf_result got %h exp 8000000000000000", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL div_ovf_latency got %0d exp 65", lat); end
        run_op(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL rem_ovf_result got %h exp 0", res); end
        run_op(OP_DIVU, 64'd100, 64'd7, 5'd16, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'd14) begin errors++; $display("FAIL divu_result got %h exp e", res); end
        run_op(OP_REMU, 64'd100, 64'd7, 5'd17, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'd2) begin errors++; $display("FAIL remu_result got %h exp 2", res); end
        checks++; if (rdo !== 5'd17) begin errors++; $display("FAIL remu_rd_out got %0d exp 17", rdo); end
    endtask
`else
    task automatic test_div_disabled();
        logic [63:0] res; logic [4:0] rdo; logic wr; int lat; logic b0;
        run_op(OP_MUL, 64'd5, 64'd5, 5'd4, res, rdo, wr, lat, b0);
        run_op(OP_DIV, 64'd9, 64'd3, 5'd20, res, rdo, wr, lat, b0);
        checks++; if (lat !== 0) begin errors++; $display("FAIL divoff_latency got %0d exp 0", lat); end
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL divoff_result got %h exp 0", res); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL divoff_writereg got %b exp 1", wr); end
        checks++; if (rdo !== 5'd20) begin errors++; $display("FAIL divoff_rd_out got %0d exp 20", rdo); end
        run_op(OP_REMU, 64'd9, 64'd3, 5'd21, res, rdo, wr, lat, b0);
        checks++; if (lat !== 0) begin errors++; $display("FAIL remuoff_latency got %0d exp 0", lat); end
    endtask
`endif

    task automatic test_start_ignored();
        int ndone; int first_k; logic [63:0] res; logic [4:0] rdo;
        ndone = 0; first_k = -1; res = '0; rdo = 5'd0;
        @(negedge clock);
        start = 1'b1; op = OP_MUL; rs1_data = 64'd5; rs2_data = 64'd6; rd_in = 5'd9;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k >= 2 && k <= 4) begin
                start = 1'b1; op = OP_MULHU; rs1_data = 64'hFFFF_FFFF_FFFF_FFFF;
                rs2_data = 64'hFFFF_FFFF_FFFF_FFFF; rd_in = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin first_k = k; res = result; rdo = rd_out; end
            end
            @(negedge clock);
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
        checks++; if (first_k !== 65) begin errors++; $display("FAIL ignore_latency got %0d exp 65", first_k); end
        checks++; if (res !== 64'd30) begin errors++; $display("FAIL ignore_result got %h exp 1e", res); end
        checks++; if (rdo !== 5'd9) begin errors++; $display("FAIL ignore_rd_out got %0d exp 9", rdo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_abort();
        logic saw_done; logic [63:0] res; logic [4:0] rdo; logic wr; int lat; logic b0;
        saw_done = 1'b0;
        @(negedge clock);
        start = 1'b1; op = OP_MUL; rs1_data = 64'd7; rs2_data = 64'd3; rd_in = 5'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL abort_result got %h exp 0", result); end
        @(negedge clock);
        reset = 1'b1;
        repeat (80) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
        run_op(OP_MUL, 64'd11, 64'hFFFF_FFFF_FFFF_FFFE, 5'd8, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEA) begin errors++; $display("FAIL abort_next_result got %h exp ffffffffffffffea", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL abort_next_latency got %0d exp 65", lat); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res; logic [4:0] rdo; logic wr; int lat; logic b0;
        run_op(OP_MUL, 64'd3, 64'd4, 5'd6, res, rdo, wr, lat, b0);
        checks++; if (res !== 64'd12) begin errors++; $display("FAIL b2b_first_result got %h exp c", res); end
        run_op(OP_MULHU, 64'h8000_0000_0000_0000, 64'd4, 5'd7, res, rdo, wr, lat, b0);
        checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_second_latency got %0d exp 65", lat); end
        checks++; if (res !== 64'd2) begin errors++; $display("FAIL b2b_second_result got %h exp 2", res); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b exp 0", done); end
        checks++; if (writereg !== 1'b0) begin errors++; $display("FAIL b2b_writereg_low got %b exp 0", writereg); end
        checks++; if (result !== 64'd2) begin errors++; $display("FAIL b2b_result_hold got %h exp 2", result); end
        checks++; if (rd_out !== 5'd7) begin errors++; $display("FAIL b2b_rd_hold got %0d exp 7", rd_out); end
    endtask

    // Run all scenarios in sequence and print the summary.
    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0; rd_in = 5'd0;
        test_reset();
        test_mul();
        test_mulh();
`ifdef MUL_DIV_UNIT_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
